// File: rtl/gmii_gen_pkg.sv
// Shared types and constants for the GMII receive-side frame generator.
package gmii_gen_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_PREAMBLE = 4'd1,
        ST_SFD      = 4'd2,
        ST_DST      = 4'd3,
        ST_SRC      = 4'd4,
        ST_LEN      = 4'd5,
        ST_PAYLOAD  = 4'd6,
        ST_PAD      = 4'd7,
        ST_FCS      = 4'd8,
        ST_IFG      = 4'd9
    } gen_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

    // FCS byte idx (0 = first on the wire) of the complemented CRC.
    function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
        logic [31:0] f;
        f = ~crc;
        case (idx)
            2'd0:    return f[7:0];
            2'd1:    return f[15:8];
            2'd2:    return f[23:16];
            2'd3:    return f[31:24];
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/gmii_frame_gen_crc32_d8.sv
// Combinational CRC32 (reflected) update by one data byte, LSB first.
module crc32_d8
    import gmii_gen_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    logic [31:0] c_s;

    // Fold the eight data bits into the running CRC, bit 0 first.
    always_comb begin
        c_s = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c_s[0] ^ data_in[i]) begin
                c_s = (c_s >> 1) ^ CRC_POLY;
            end else begin
                c_s = c_s >> 1;
            end
        end
        crc_out = c_s;
    end

endmodule

// File: rtl/gmii_frame_gen.sv
// GMII rx frame generator: preamble, SFD, header, paced payload, pad, FCS, IFG.
module gmii_frame_gen
    import gmii_gen_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int BYTE_REPEAT  = 2,
    parameter int MIN_PAYLOAD  = 46,
    parameter int MAX_PAYLOAD  = 1500,
    parameter int APPEND_FCS   = 1,
    parameter int IFG_BYTES    = 12
) (
    input  logic        gmii_rx_clk,
    input  logic        reset,
    input  logic        start,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    input  logic [15:0] len_type,
    input  logic [7:0]  pl_data,
    input  logic        pl_valid,
    input  logic        pl_last,
    output logic        pl_ready,
    output logic [7:0]  gmii_rxd,
    output logic        gmii_rx_dv,
    output logic        gmii_rx_er,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_err
);

    localparam logic [3:0]  SLOT_LAST = 4'(BYTE_REPEAT - 1);
    localparam logic [10:0] MAX_CNT   = 11'(MAX_PAYLOAD);
    localparam logic [10:0] MIN_CNT   = 11'(MIN_PAYLOAD);
    localparam logic [15:0] PRE_LAST  = 16'(PREAMBLE_LEN - 1);
    localparam logic [15:0] IFG_LAST  = 16'(IFG_BYTES - 1);

    gen_state_e    state_q, state_d;
    logic [3:0]    slot_q, slot_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [10:0]   pay_cnt_q, pay_cnt_d;
    logic [111:0]  hdr_q, hdr_d;
    logic [31:0]   crc_q, crc_d;
    logic          pay_end_q, pay_end_d;
    logic [7:0]    rxd_q, rxd_d;
    logic          dv_q, dv_d, er_q, er_d, busy_q, busy_d;
    logic          done_q, done_d, err_q, err_d, ready_q, ready_d;

    logic [31:0]   crc_next_s, crc_cur_s;
    logic          tick_s, crc_en_s, next_pay_s;
    logic          enter_pay_s, enter_fcs_s, enter_ifg_s;
    logic [10:0]   pay_inc_s;

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data_in (rxd_q),
        .crc_out (crc_next_s)
    );

    // Slot boundary, saturating payload increment and the CRC value seen this cycle.
    always_comb begin
        tick_s    = (slot_q == SLOT_LAST);
        pay_inc_s = (pay_cnt_q == MAX_CNT) ? pay_cnt_q : pay_cnt_q + 11'd1;
        crc_en_s  = (state_q inside {ST_DST, ST_SRC, ST_LEN, ST_PAYLOAD, ST_PAD}) && !er_q;
        crc_cur_s = (crc_en_s && (slot_q == 4'd0)) ? crc_next_s : crc_q;
    end

    // Next-state and next-slot output computation; a new byte is loaded only on a tick.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        cnt_d       = cnt_q;
        pay_cnt_d   = pay_cnt_q;
        hdr_d       = hdr_q;
        crc_d       = crc_cur_s;
        pay_end_d   = pay_end_q;
        rxd_d       = rxd_q;
        dv_d        = dv_q;
        er_d        = er_q;
        busy_d      = busy_q;
        err_d       = err_q;
        enter_pay_s = 1'b0;
        enter_fcs_s = 1'b0;
        enter_ifg_s = 1'b0;

        if (state_q == ST_IDLE) begin
            slot_d = 4'd0;
            crc_d  = CRC_INIT;
            if (start) begin
                state_d   = ST_PREAMBLE;
                cnt_d     = 16'd0;
                pay_cnt_d = 11'd0;
                pay_end_d = 1'b0;
                hdr_d     = {dst_mac, src_mac, len_type};
                rxd_d     = PREAMBLE_BYTE;
                dv_d      = 1'b1;
                er_d      = 1'b0;
                busy_d    = 1'b1;
                err_d     = 1'b0;
            end else begin
                busy_d = 1'b0;
            end
        end else if (!tick_s) begin
            slot_d = slot_q + 4'd1;
        end else begin
            slot_d = 4'd0;
            case (state_q)
                ST_PREAMBLE: begin
                    if (cnt_q == PRE_LAST) begin
                        state_d = ST_SFD;
                        cnt_d   = 16'd0;
                        rxd_d   = SFD_BYTE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                        rxd_d = PREAMBLE_BYTE;
                    end
                end
                ST_SFD: begin
                    state_d = ST_DST;
                    cnt_d   = 16'd0;
                    rxd_d   = hdr_q[111:104];
                    hdr_d   = {hdr_q[103:0], 8'h00};
                end
                ST_DST, ST_SRC: begin
                    rxd_d = hdr_q[111:104];
                    hdr_d = {hdr_q[103:0], 8'h00};
                    if (cnt_q == 16'd5) begin
                        state_d = (state_q == ST_DST) ? ST_SRC : ST_LEN;
                        cnt_d   = 16'd0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_LEN: begin
                    if (cnt_q == 16'd0) begin
                        cnt_d = 16'd1;
                        rxd_d = hdr_q[111:104];
                        hdr_d = {hdr_q[103:0], 8'h00};
                    end else begin
                        enter_pay_s = 1'b1;
                    end
                end
                ST_PAYLOAD: begin
                    if (!pay_end_q) begin
                        enter_pay_s = 1'b1;
                    end else if (er_q) begin
                        enter_ifg_s = 1'b1;
                    end else if (pay_cnt_q < MIN_CNT) begin
                        state_d   = ST_PAD;
                        rxd_d     = 8'h00;
                        pay_cnt_d = pay_inc_s;
                    end else if (APPEND_FCS != 0) begin
                        enter_fcs_s = 1'b1;
                    end else begin
                        enter_ifg_s = 1'b1;
                    end
                end
                ST_PAD: begin
                    if (pay_cnt_q < MIN_CNT) begin
                        rxd_d     = 8'h00;
                        pay_cnt_d = pay_inc_s;
                    end else if (APPEND_FCS != 0) begin
                        enter_fcs_s = 1'b1;
                    end else begin
                        enter_ifg_s = 1'b1;
                    end
                end
                ST_FCS: begin
                    if (cnt_q == 16'd3) begin
                        enter_ifg_s = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                        rxd_d = fcs_byte(crc_cur_s, cnt_q[1:0] + 2'd1);
                    end
                end
                ST_IFG: begin
                    if (cnt_q == IFG_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = 16'd0;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    dv_d    = 1'b0;
                    er_d    = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end

        // Payload slot: take a byte, or mark an underrun slot when none is offered.
        if (enter_pay_s) begin
            state_d = ST_PAYLOAD;
            if (pl_valid) begin
                rxd_d     = pl_data;
                er_d      = 1'b0;
                pay_cnt_d = pay_inc_s;
                pay_end_d = pl_last || (pay_inc_s == MAX_CNT);
                err_d     = err_q || (!pl_last && (pay_inc_s == MAX_CNT));
            end else begin
                rxd_d     = 8'h00;
                er_d      = 1'b1;
                pay_end_d = 1'b1;
                err_d     = 1'b1;
            end
        end else begin
            pay_end_d = pay_end_d;
        end

        if (enter_fcs_s) begin
            state_d = ST_FCS;
            cnt_d   = 16'd0;
            rxd_d   = fcs_byte(crc_cur_s, 2'd0);
        end else begin
            cnt_d = cnt_d;
        end

        if (enter_ifg_s) begin
            state_d = ST_IFG;
            cnt_d   = 16'd0;
            rxd_d   = 8'h00;
            dv_d    = 1'b0;
            er_d    = 1'b0;
        end else begin
            dv_d = dv_d;
        end

        // Ready is raised on the tick of the slot that precedes a payload slot.
        next_pay_s = ((state_d == ST_LEN) && (cnt_d == 16'd1)) ||
                     ((state_d == ST_PAYLOAD) && !pay_end_d);
        ready_d    = (slot_d == SLOT_LAST) && next_pay_s;
        done_d     = (state_d == ST_IFG) && (cnt_d == IFG_LAST) && (slot_d == SLOT_LAST);
    end

    // State and output registers; reset drops the bus at once.
    always_ff @(posedge gmii_rx_clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            slot_q    <= 4'd0;
            cnt_q     <= 16'd0;
            pay_cnt_q <= 11'd0;
            hdr_q     <= 112'd0;
            crc_q     <= CRC_INIT;
            pay_end_q <= 1'b0;
            rxd_q     <= 8'h00;
            dv_q      <= 1'b0;
            er_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            cnt_q     <= cnt_d;
            pay_cnt_q <= pay_cnt_d;
            hdr_q     <= hdr_d;
            crc_q     <= crc_d;
            pay_end_q <= pay_end_d;
            rxd_q     <= rxd_d;
            dv_q      <= dv_d;
            er_q      <= er_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
        end
    end

    assign pl_ready   = ready_q;
    assign gmii_rxd   = rxd_q;
    assign gmii_rx_dv = dv_q;
    assign gmii_rx_er = er_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_gmii_frame_gen.sv
// Randomised bench for gmii_frame_gen: two instances (half rate / full rate with
// a small payload limit) checked against a byte-list model of the frame.
module tb_gmii_frame_gen;
    import gmii_gen_pkg::*;

    localparam int PRE  = 7;
    localparam int MINP = 46;
    localparam int IFGB = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        start_s[2];
    logic [47:0] dst_s[2];
    logic [47:0] src_s[2];
    logic [15:0] lt_s[2];
    logic [7:0]  pld_s[2];
    logic        plv_s[2];
    logic        pll_s[2];

    logic [7:0] rxd_a, rxd_b;
    logic dv_a, dv_b, er_a, er_b, rdy_a, rdy_b, busy_a, busy_b, done_a, done_b, ferr_a, ferr_b;

    logic [7:0]  pay_q[$];
    logic [47:0] h_dst, h_src;
    logic [15:0] h_lt;

    logic [31:0] cu_in, cu_out;
    logic [7:0]  cu_d;

    gmii_frame_gen #(.BYTE_REPEAT(2), .MAX_PAYLOAD(1500)) u_dut_a (
        .gmii_rx_clk(clk), .reset(rst_n), .start(start_s[0]), .dst_mac(dst_s[0]),
        .src_mac(src_s[0]), .len_type(lt_s[0]), .pl_data(pld_s[0]), .pl_valid(plv_s[0]),
        .pl_last(pll_s[0]), .pl_ready(rdy_a), .gmii_rxd(rxd_a), .gmii_rx_dv(dv_a),
        .gmii_rx_er(er_a), .busy(busy_a), .frame_done(done_a), .frame_err(ferr_a));

    gmii_frame_gen #(.BYTE_REPEAT(1), .MAX_PAYLOAD(64)) u_dut_b (
        .gmii_rx_clk(clk), .reset(rst_n), .start(start_s[1]), .dst_mac(dst_s[1]),
        .src_mac(src_s[1]), .len_type(lt_s[1]), .pl_data(pld_s[1]), .pl_valid(plv_s[1]),
        .pl_last(pll_s[1]), .pl_ready(rdy_b), .gmii_rxd(rxd_b), .gmii_rx_dv(dv_b),
        .gmii_rx_er(er_b), .busy(busy_b), .frame_done(done_b), .frame_err(ferr_b));

    crc32_d8 u_crc_unit (.crc_in(cu_in), .data_in(cu_d), .crc_out(cu_out));

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int g, output logic [7:0] rxd, output logic dv, output logic er,
                          output logic rdy, output logic bz, output logic dn, output logic fe);
        if (g == 0) begin
            rxd = rxd_a; dv = dv_a; er = er_a; rdy = rdy_a; bz = busy_a; dn = done_a; fe = ferr_a;
        end else begin
            rxd = rxd_b; dv = dv_b; er = er_b; rdy = rdy_b; bz = busy_b; dn = done_b; fe = ferr_b;
        end
    endtask

    // Standard Ethernet FCS over a byte list (complemented reflected CRC32).
    function automatic logic [31:0] ref_fcs(input logic [7:0] b[$]);
        logic [31:0] c;
        logic fb;
        c = 32'hFFFFFFFF;
        foreach (b[k]) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ b[k][j];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    task automatic fill_payload(input int n);
        pay_q.delete();
        for (int k = 0; k < n; k++) pay_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic rand_header();
        h_dst = {16'($urandom), 32'($urandom)};
        h_src = {16'($urandom), 32'($urandom)};
        h_lt  = 16'($urandom);
    endtask

    // One frame on instance g: n payload bytes (pl_last on the n-th when use_last),
    // under_at >= 0 withholds pl_valid at that byte index.
    task automatic run_frame(input int g, input int n, input int under_at, input bit use_last,
                             input string tag);
        logic [8:0]  exp_q[$];
        logic [8:0]  obs_q[$];
        logic [7:0]  body[$];
        logic [111:0] hdr;
        logic [31:0] fcs;
        logic [7:0]  rxd;
        logic dv, er, rdy, bz, dn, fe, exp_err, busy1, fe1, done;
        int br, maxp, acc, exp_ready, cyc, idx, first_dv, ready_cnt, ifg_cnt, ncmp;

        br   = (g == 0) ? 2 : 1;
        maxp = (g == 0) ? 1500 : 64;
        hdr  = {h_dst, h_src, h_lt};
        for (int k = 0; k < PRE; k++) exp_q.push_back(9'h055);
        exp_q.push_back(9'h0D5);
        for (int k = 0; k < 14; k++) body.push_back(hdr[111 - 8*k -: 8]);
        if (under_at >= 0) acc = under_at;
        else if (use_last) acc = n;
        else acc = maxp;
        for (int k = 0; k < acc; k++) body.push_back(pay_q[k]);
        if (under_at < 0) while (body.size() < 14 + MINP) body.push_back(8'h00);
        foreach (body[k]) exp_q.push_back({1'b0, body[k]});
        if (under_at >= 0) begin
            exp_q.push_back(9'h100);
            exp_err   = 1'b1;
            exp_ready = under_at + 1;
        end else begin
            fcs = ref_fcs(body);
            for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, fcs[8*k +: 8]});
            exp_err   = !use_last;
            exp_ready = acc;
        end

        @(negedge clk);
        start_s[g] = 1'b1; dst_s[g] = h_dst; src_s[g] = h_src; lt_s[g] = h_lt;
        cyc = 0; idx = 0; first_dv = -1; ready_cnt = 0; ifg_cnt = 0;
        done = 1'b0; busy1 = 1'b0; fe1 = 1'b1; fe = 1'b0;
        while (!done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            start_s[g] = 1'b0;
            sample(g, rxd, dv, er, rdy, bz, dn, fe);
            if (cyc == 1) begin busy1 = bz; fe1 = fe; end
            if (dv) begin
                if (first_dv < 0) first_dv = cyc;
                obs_q.push_back({er, rxd});
            end else if (first_dv >= 0) begin
                ifg_cnt++;
            end
            if (rdy) ready_cnt++;
            if (dn) done = 1'b1;
            plv_s[g] = !(under_at >= 0 && idx == under_at);
            pld_s[g] = (idx < pay_q.size()) ? pay_q[idx] : 8'h00;
            pll_s[g] = use_last && (idx == n - 1);
            if (rdy && plv_s[g]) idx++;
        end
        plv_s[g] = 1'b0; pll_s[g] = 1'b0;

        check_eq({tag, "_done"}, 64'(done), 64'd1);
        check_eq({tag, "_first_dv"}, 64'(first_dv), 64'd1);
        check_eq({tag, "_busy_after_start"}, 64'(busy1), 64'd1);
        check_eq({tag, "_err_cleared"}, 64'(fe1), 64'd0);
        check_eq({tag, "_dv_cycles"}, 64'(obs_q.size()), 64'(exp_q.size() * br));
        ncmp = (obs_q.size() < exp_q.size() * br) ? obs_q.size() : exp_q.size() * br;
        for (int i = 0; i < ncmp; i++)
            check_eq($sformatf("%s_cyc%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i / br]));
        check_eq({tag, "_ready_pulses"}, 64'(ready_cnt), 64'(exp_ready));
        check_eq({tag, "_ifg_cycles"}, 64'(ifg_cnt), 64'(IFGB * br));
        check_eq({tag, "_frame_err"}, 64'(fe), 64'(exp_err));
        @(negedge clk);
        sample(g, rxd, dv, er, rdy, bz, dn, fe);
        check_eq({tag, "_idle_busy"}, 64'(bz), 64'd0);
        check_eq({tag, "_idle_dv"}, 64'(dv), 64'd0);
    endtask

    initial begin : main
        string s;
        logic [31:0] cur, fin;
        logic [7:0] rxd;
        logic dv, er, rdy, bz, dn, fe;
        int n, g, u;

        for (int k = 0; k < 2; k++) begin
            start_s[k] = 1'b0; dst_s[k] = 48'd0; src_s[k] = 48'd0; lt_s[k] = 16'd0;
            pld_s[k] = 8'd0; plv_s[k] = 1'b0; pll_s[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            sample(k, rxd, dv, er, rdy, bz, dn, fe);
            check_eq($sformatf("reset_outs%0d", k), {56'd0, rxd, dv, er, rdy, bz, dn, fe}, 64'd0);
        end
        rst_n = 1'b1;

        // CRC check vector
        s = "123456789";
        cur = CRC_INIT;
        for (int i = 0; i < 9; i++) begin
            cu_in = cur; cu_d = s[i]; #1; cur = cu_out;
        end
        fin = ~cur;
        check_eq("crc_check_value", 64'(fin), 64'hCBF43926);

        // Reference frame: 4-byte payload, 42 pad bytes
        h_dst = 48'h0EDA02030405; h_src = 48'h065A02030405; h_lt = 16'h002E;
        pay_q.delete();
        pay_q.push_back(8'hFF); pay_q.push_back(8'hFF); pay_q.push_back(8'hAA); pay_q.push_back(8'hDD);
        run_frame(0, 4, -1, 1'b1, "short_pad");

        rand_header(); fill_payload(60);
        run_frame(1, 60, -1, 1'b1, "full_rate_60");

        rand_header(); fill_payload(20);
        run_frame(0, 20, 10, 1'b1, "underrun_a");
        rand_header(); fill_payload(20);
        run_frame(1, 20, 10, 1'b1, "underrun_b");

        rand_header(); fill_payload(80);
        run_frame(1, 80, -1, 1'b0, "max_trunc");

        rand_header(); fill_payload(64);
        run_frame(1, 64, -1, 1'b1, "last_at_max");

        for (int r = 0; r < 8; r++) begin
            rand_header();
            g = $urandom_range(0, 1);
            n = (g == 0) ? $urandom_range(1, 100) : $urandom_range(1, 64);
            u = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            fill_payload(n);
            run_frame(g, n, u, 1'b1, $sformatf("rand%0d", r));
        end

        // Reset during SRC, then a clean frame
        rand_header();
        @(negedge clk);
        start_s[0] = 1'b1; dst_s[0] = h_dst; src_s[0] = h_src; lt_s[0] = h_lt;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (30) @(negedge clk);
        sample(0, rxd, dv, er, rdy, bz, dn, fe);
        check_eq("pre_reset_dv", 64'(dv), 64'd1);
        #2 rst_n = 1'b0;
        #1 sample(0, rxd, dv, er, rdy, bz, dn, fe);
        check_eq("async_reset_dv", 64'(dv), 64'd0);
        check_eq("async_reset_busy", 64'(bz), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rand_header(); fill_payload(50);
        run_frame(0, 50, -1, 1'b1, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gmii_frame_gen.md
Name: gmii_frame_gen

Overview:
Synthesisable, parametrised GMII receive-side frame generator. It emits complete Ethernet frames on a GMII rx bus toward the MAC under test: preamble, SFD, header, streamed payload, zero-pad and computed FCS. It replaces hand-sequenced bench stimulus and adds configurable byte pacing, automatic padding, CRC32, inter-frame gap and underrun error signalling. It serves both as a bench driver and as an on-chip loopback/self-test source.

Parameters:
PREAMBLE_LEN, 7, count of 0x55 bytes before SFD (1..15)
BYTE_REPEAT, 2, clock cycles each byte is held on the bus (1 = GMII rate, 2 = half rate)
MIN_PAYLOAD, 46, payload bytes below which zero padding is appended
MAX_PAYLOAD, 1500, payload byte limit; reaching it forces end of payload
APPEND_FCS, 1, 1 = append CRC32 FCS, 0 = omit it
IFG_BYTES, 12, idle byte slots enforced after each frame

Ports:
gmii_rx_clk  in  1  sole clock
reset  in  1  asynchronous, active-low reset
start  in  1  request one frame; sampled only in IDLE
dst_mac  in  48  destination MAC; [47:40] sent first; captured at start
src_mac  in  48  source MAC; [47:40] sent first; captured at start
len_type  in  16  length/type field; [15:8] sent first; captured at start
pl_data  in  8  payload byte
pl_valid  in  1  payload byte available
pl_last  in  1  marks final payload byte
pl_ready  out  1  payload byte consumed this cycle
gmii_rxd  out  8  GMII data
gmii_rx_dv  out  1  GMII data valid
gmii_rx_er  out  1  GMII error
busy  out  1  high from the cycle after start through the end of IFG
frame_done  out  1  one-cycle pulse on the last IFG cycle
frame_err  out  1  valid with frame_done: underrun occurred or MAX_PAYLOAD truncation

Behaviour:
- Reset: all outputs 0; FSM in IDLE; CRC register = 0xFFFFFFFF. Asserting reset mid-frame drops gmii_rx_dv immediately with no FCS.
- Slot timer: counts 0..BYTE_REPEAT-1. A slot boundary ("tick") is the cycle where the count equals BYTE_REPEAT-1. Outputs are registered and stay constant for the whole slot.
- FSM states: IDLE, PREAMBLE, SFD, DST, SRC, LEN, PAYLOAD, PAD, FCS, IFG.
- IDLE: when start=1, capture the header fields. The first preamble byte appears on the next cycle, with dv=1.
- Transitions, each taken on a tick:
  - PREAMBLE: PREAMBLE_LEN slots of 0x55, then SFD.
  - SFD: one slot of 0xD5, then DST.
  - DST: 6 slots, then SRC.
  - SRC: 6 slots, then LEN.
  - LEN: 2 slots, then PAYLOAD.
  - PAYLOAD: exits on last byte or MAX_PAYLOAD.
  - PAD: sends 0x00 until the payload count reaches MIN_PAYLOAD.
  - FCS: 4 slots.
  - IFG: IFG_BYTES slots with dv=0 and rxd=0, then IDLE.
- Payload handshake: pl_ready = 1 only in the cycle before a PAYLOAD slot starts, i.e. the tick of the preceding slot. A byte is taken when pl_valid & pl_ready.
  - If pl_last is taken: go to PAD if count < MIN_PAYLOAD, else FCS (or IFG when APPEND_FCS=0).
  - If count reaches MAX_PAYLOAD without pl_last: go to FCS and latch err.
- Underrun: if pl_valid=0 when pl_ready=1, drive dv=1, er=1, rxd=0x00 for one slot, skip PAD and FCS, go to IFG, and latch err.
- Payload counter: 11 bits, saturates at MAX_PAYLOAD and never wraps.
- CRC32: reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF. Updated once per slot, on the slot's first cycle, for DST through PAD bytes. FCS is the complemented CRC, sent LSB byte first. CRC reinitialises in IDLE.
- Simultaneous events: start while busy is ignored; pl_last together with MAX_PAYLOAD is a normal end (no err); frame_err is cleared at the next start.
- Latency: start, then 1 cycle, then dv high for (PREAMBLE_LEN+1+14+max(n,MIN_PAYLOAD)+4·APPEND_FCS)·BYTE_REPEAT cycles.

Decomposition:
- Package gmii_gen_pkg holds: FSM state enum, constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC_POLY=32'hEDB88320, CRC_INIT=32'hFFFFFFFF.
- Sub-module crc32_d8 is combinational: next CRC from the current CRC and one data byte.
- The FSM, slot timer and counters stay in gmii_frame_gen.

Test Plan:
- crc32_d8 fed ASCII "123456789" from CRC_INIT, final value complemented -> 0xCBF43926.
- Defaults; dst=0x0EDA02030405, src=0x065A02030405, len_type=0x002E; payload FF FF AA DD with last -> 7×0x55 and 0xD5, each byte held 2 cycles; 42 pad zeros; FCS matches the software model; dv high 144 cycles; frame_done after 24 IFG cycles; frame_err=0.
- BYTE_REPEAT=1, 60-byte payload -> no PAD state; dv high 86 cycles; exactly 60 pl_ready pulses.
- pl_valid dropped after 10 bytes -> one slot with er=1, dv=1; no FCS; frame_done with frame_err=1.
- MAX_PAYLOAD=64 with no pl_last -> exactly 64 bytes taken, FCS sent, frame_err=1.
- reset asserted during SRC -> dv and busy go 0 asynchronously; after release, start produces a clean frame with a correct FCS.
